// File: rtl/cr_pipe_pkg.sv
// cr_pipe_pkg: shared constants and helpers for the cr_pipe_reg_hs elastic pipe.
// Optional feature macro: CR_PIPE_REG_HS_FLUSH_EN (adds a synchronous Flush input).
package cr_pipe_pkg;

    // Each skid stage holds a main word and a skid word.
    localparam int CR_PIPE_SKID_DEPTH = 2;

    // Width of the occupancy counter: enough for 0..DEPTH*stages, at least 1 bit.
    function automatic int clog2_cnt(input int stages);
        if (stages == 0)
            return 1;
        else
            return $clog2(CR_PIPE_SKID_DEPTH * stages + 1);
    endfunction

endpackage

// File: rtl/cr_pipe_reg_hs_if.sv
// cr_pipe_reg_hs_if: one valid/ready payload channel.
// Optional feature macro of the block: CR_PIPE_REG_HS_FLUSH_EN (not used here).
//
// Handshake: a word moves in every cycle where Valid && Ready is high at the
// rising clock edge. The master holds Valid and Data stable until that transfer;
// Ready may change freely and must not depend on a future Valid.
interface cr_pipe_reg_hs_if #(
    parameter int pWidth = 10
);
    logic              Valid;
    logic              Ready;
    logic [pWidth-1:0] Data;

    modport master (output Valid, output Data, input Ready);
    modport slave  (input Valid, input Data, output Ready);
endinterface

// File: rtl/cr_pipe_skid.sv
// cr_pipe_skid: one elastic stage with a main and a skid register.
// in_ready comes straight from a flop (!skid_valid), so ready never chains
// combinationally through the pipe.
// Optional feature macro: CR_PIPE_REG_HS_FLUSH_EN (adds Flush input).
module cr_pipe_skid #(
    parameter int pWidth = 10
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [pWidth-1:0] StaticResetData,
`ifdef CR_PIPE_REG_HS_FLUSH_EN
    input  logic              Flush,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [pWidth-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [pWidth-1:0] out_data
);

    logic              main_valid;
    logic              skid_valid;
    logic [pWidth-1:0] main_data;
    logic [pWidth-1:0] skid_data;
    logic              in_xfer;
    logic              out_xfer;

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = main_valid && out_ready;

    // Main/skid occupancy update; data registers keep stale values when emptied.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= StaticResetData;
            skid_data  <= StaticResetData;
        end
`ifdef CR_PIPE_REG_HS_FLUSH_EN
        else if (Flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end
`endif
        else begin
            if (out_xfer) begin
                if (skid_valid) begin
                    // in_ready is low here, so no input word competes.
                    main_data  <= skid_data;
                    skid_valid <= 1'b0;
                end else begin
                    main_valid <= in_xfer;
                    if (in_xfer)
                        main_data <= in_data;
                end
            end else if (in_xfer) begin
                if (!main_valid) begin
                    main_valid <= 1'b1;
                    main_data  <= in_data;
                end else begin
                    skid_valid <= 1'b1;
                    skid_data  <= in_data;
                end
            end
        end
    end

endmodule

// File: rtl/cr_pipe_reg_hs.sv
// cr_pipe_reg_hs: chain of pStages elastic skid stages with an occupancy count.
// pStages=0 degenerates to a combinational passthrough.
// Optional feature macro: CR_PIPE_REG_HS_FLUSH_EN (adds Flush input that
// empties every stage and zeroes Count; reset has priority).
module cr_pipe_reg_hs
    import cr_pipe_pkg::*;
#(
    parameter int pWidth  = 10,
    parameter int pStages = 2,
    parameter int pCntW   = clog2_cnt(pStages)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [pWidth-1:0] StaticResetData,
`ifdef CR_PIPE_REG_HS_FLUSH_EN
    input  logic              Flush,
`endif
    cr_pipe_reg_hs_if.slave   up,     // InValid / InReady / D
    cr_pipe_reg_hs_if.master  dn,     // OutValid / OutReady / Q
    output logic [pCntW-1:0]  Count
);

    generate
        if (pStages == 0) begin : g_pass
            assign dn.Valid = up.Valid;
            assign dn.Data  = up.Data;
            assign up.Ready = dn.Ready;
            assign Count    = '0;
        end else begin : g_chain
            logic [pStages:0] v;
            logic [pStages:0] r;
            logic [pWidth-1:0] d_a [pStages+1];
            logic [pCntW-1:0] cnt;
            logic in_xfer;
            logic out_xfer;

            assign v[0]     = up.Valid;
            assign d_a[0]   = up.Data;
            assign up.Ready = r[0];
            assign dn.Valid = v[pStages];
            assign dn.Data  = d_a[pStages];
            assign r[pStages] = dn.Ready;

            for (genvar k = 0; k < pStages; k++) begin : g_stage
                cr_pipe_skid #(.pWidth(pWidth)) u_skid (
                    .Clk             (Clk),
                    .Rst_n           (Rst_n),
                    .StaticResetData (StaticResetData),
`ifdef CR_PIPE_REG_HS_FLUSH_EN
                    .Flush           (Flush),
`endif
                    .in_valid        (v[k]),
                    .in_ready        (r[k]),
                    .in_data         (d_a[k]),
                    .out_valid       (v[k+1]),
                    .out_ready       (r[k+1]),
                    .out_data        (d_a[k+1])
                );
            end

            assign in_xfer  = up.Valid && r[0];
            assign out_xfer = v[pStages] && dn.Ready;
            assign Count    = cnt;

            // Occupancy: +1 per accepted word, -1 per delivered word.
            always_ff @(posedge Clk) begin
                if (!Rst_n)
                    cnt <= '0;
`ifdef CR_PIPE_REG_HS_FLUSH_EN
                else if (Flush)
                    cnt <= '0;
`endif
                else if (in_xfer && !out_xfer)
                    cnt <= cnt + pCntW'(1);
                else if (!in_xfer && out_xfer)
                    cnt <= cnt - pCntW'(1);
            end
        end
    endgenerate

endmodule

// File: tb/tb_cr_pipe_reg_hs.sv
// tb_cr_pipe_reg_hs: scoreboard bench for cr_pipe_reg_hs (pWidth=8, pStages=3)
// plus a pStages=0 passthrough instance.
// Optional feature macro: CR_PIPE_REG_HS_FLUSH_EN (enables the flush scenario).
module tb_cr_pipe_reg_hs;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Rst_n;
    logic [W-1:0] StaticResetData;
    logic         Flush;
    logic [2:0]   Count;
    logic [0:0]   z_count;

    logic [W-1:0] exp_q[$];
    int           mdl_cnt;
    int           n_vec;
    int           n_err;

    cr_pipe_reg_hs_if #(.pWidth(W)) up_if ();
    cr_pipe_reg_hs_if #(.pWidth(W)) dn_if ();
    cr_pipe_reg_hs_if #(.pWidth(W)) z_up ();
    cr_pipe_reg_hs_if #(.pWidth(W)) z_dn ();

    cr_pipe_reg_hs #(.pWidth(W), .pStages(3)) dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .StaticResetData (StaticResetData),
`ifdef CR_PIPE_REG_HS_FLUSH_EN
        .Flush           (Flush),
`endif
        .up              (up_if),
        .dn              (dn_if),
        .Count           (Count)
    );

    cr_pipe_reg_hs #(.pWidth(W), .pStages(0)) dut_z (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .StaticResetData (StaticResetData),
`ifdef CR_PIPE_REG_HS_FLUSH_EN
        .Flush           (1'b0),
`endif
        .up              (z_up),
        .dn              (z_dn),
        .Count           (z_count)
    );

    // ---------------- clock / reset ----------------
    always #5 Clk = ~Clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one word, wait (bounded) for acceptance, push its expected copy.
    task automatic send(input logic [W-1:0] d, input int exp_cnt);
        int t;
        up_if.Valid = 1'b1;
        up_if.Data  = d;
        t = 0;
        @(negedge Clk);
        while (!up_if.Ready && t < 50) begin
            @(negedge Clk);
            t++;
        end
        if (!up_if.Ready) begin
            chk("send_timeout", 32'(up_if.Ready), 32'd1);
        end else begin
            exp_q.push_back(d);
            if (exp_cnt >= 0)
                chk("stream_count", 32'(Count), 32'(exp_cnt));
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_empty(input string name);
        int t;
        t = 0;
        while ((Count != 0 || exp_q.size() != 0) && t < 100) begin
            @(negedge Clk);
            t++;
        end
        chk(name, 32'(Count), 32'd0);
        chk({name, "_q"}, 32'(exp_q.size()), 32'd0);
        @(posedge Clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge Clk) begin
        if (!Rst_n) begin
            exp_q.delete();
            mdl_cnt = 0;
        end else begin
            chk("count_track", 32'(Count), 32'(mdl_cnt));
            if (dn_if.Valid && dn_if.Ready) begin
                if (exp_q.size() == 0)
                    chk("unexpected_out", 32'(dn_if.Data), 32'hFFFF_FFFF);
                else
                    chk("q_data", 32'(dn_if.Data), 32'(exp_q.pop_front()));
            end
            if (Flush) begin
                exp_q.delete();
                mdl_cnt = 0;
            end else begin
                mdl_cnt = mdl_cnt + int'(up_if.Valid && up_if.Ready)
                                  - int'(dn_if.Valid && dn_if.Ready);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int acc;
        int lat;
        int taken;
        logic [W-1:0] zd [4];
        logic         zv [4];
        logic         zr [4];

        n_vec = 0;
        n_err = 0;
        mdl_cnt = 0;
        Rst_n = 1'b0;
        Flush = 1'b0;
        StaticResetData = 8'hA5;
        up_if.Valid = 1'b0;
        up_if.Data  = 8'h00;
        dn_if.Ready = 1'b0;
        z_up.Valid = 1'b0;
        z_up.Data  = 8'h00;
        z_dn.Ready = 1'b0;

        // Reset: two cycles low.
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;
        @(negedge Clk);
        chk("rst_q", 32'(dn_if.Data), 32'hA5);
        chk("rst_out_valid", 32'(dn_if.Valid), 32'd0);
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_in_ready", 32'(up_if.Ready), 32'd1);
        @(posedge Clk);
        #1;

        // Latency: a single word reaches Q three cycles after acceptance.
        dn_if.Ready = 1'b1;
        send(8'h5A, 0);
        up_if.Valid = 1'b0;
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
        end while (!dn_if.Valid && lat < 20);
        chk("latency", 32'(lat), 32'd3);
        @(posedge Clk);
        #1;
        wait_empty("lat_drain");

        // Full-rate stream 0x01..0x10; occupancy settles at 3.
        for (int i = 0; i < 16; i++)
            send(8'(i + 1), (i >= 3) ? 3 : i);
        up_if.Valid = 1'b0;
        wait_empty("stream_drain");

        // Stall: exactly 6 words fit, then InReady drops.
        dn_if.Ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            up_if.Valid = 1'b1;
            up_if.Data  = 8'(8'h20 + acc);
            @(negedge Clk);
            if (up_if.Ready) begin
                exp_q.push_back(up_if.Data);
                acc++;
            end
            @(posedge Clk);
            #1;
        end
        up_if.Valid = 1'b0;
        @(negedge Clk);
        chk("stall_accepted", 32'(acc), 32'd6);
        chk("stall_count", 32'(Count), 32'd6);
        chk("stall_in_ready", 32'(up_if.Ready), 32'd0);
        @(posedge Clk);
        #1 dn_if.Ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            chk("drain_gapless", 32'(dn_if.Valid), 32'd1);
        end
        @(posedge Clk);
        #1;
        wait_empty("stall_drain");

        // Reset mid-operation with four words held.
        dn_if.Ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(8'(8'h40 + i), -1);
        up_if.Valid = 1'b0;
        @(negedge Clk);
        chk("pre_rst_count", 32'(Count), 32'd4);
        @(posedge Clk);
        #1 Rst_n = 1'b0;
        @(posedge Clk);
        #1 Rst_n = 1'b1;
        @(negedge Clk);
        chk("midrst_count", 32'(Count), 32'd0);
        chk("midrst_out_valid", 32'(dn_if.Valid), 32'd0);
        chk("midrst_q", 32'(dn_if.Data), 32'hA5);
        @(posedge Clk);
        #1 dn_if.Ready = 1'b1;
        send(8'h50, -1);
        send(8'h51, -1);
        up_if.Valid = 1'b0;
        wait_empty("midrst_drain");

`ifdef CR_PIPE_REG_HS_FLUSH_EN
        // Flush at Count=5 with a word offered: that word must vanish.
        dn_if.Ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send(8'(8'h60 + i), -1);
        up_if.Valid = 1'b1;
        up_if.Data  = 8'hEE;
        Flush = 1'b1;
        @(negedge Clk);
        chk("flush_pre_count", 32'(Count), 32'd5);
        @(posedge Clk);
        #1 Flush = 1'b0;
        up_if.Valid = 1'b0;
        @(negedge Clk);
        chk("flush_count", 32'(Count), 32'd0);
        chk("flush_out_valid", 32'(dn_if.Valid), 32'd0);
        chk("flush_in_ready", 32'(up_if.Ready), 32'd1);
        @(posedge Clk);
        #1 dn_if.Ready = 1'b1;
        send(8'h77, -1);
        up_if.Valid = 1'b0;
        wait_empty("flush_drain");
`endif

        // Random valid/ready traffic; monitor checks data and Count each cycle.
        taken = 1;
        for (int c = 0; c < 10000; c++) begin
            if (!up_if.Valid || taken != 0) begin
                up_if.Valid = 1'($urandom_range(0, 1));
                up_if.Data  = 8'($urandom_range(0, 255));
            end
            dn_if.Ready = 1'($urandom_range(0, 1));
            @(negedge Clk);
            taken = int'(up_if.Valid && up_if.Ready);
            if (taken != 0)
                exp_q.push_back(up_if.Data);
            @(posedge Clk);
            #1;
        end
        up_if.Valid = 1'b0;
        dn_if.Ready = 1'b1;
        wait_empty("rand_drain");

        // pStages=0 passthrough: outputs follow inputs in the same cycle.
        zd[0] = 8'h3C; zv[0] = 1'b1; zr[0] = 1'b0;
        zd[1] = 8'hC3; zv[1] = 1'b0; zr[1] = 1'b1;
        zd[2] = 8'hFF; zv[2] = 1'b1; zr[2] = 1'b1;
        zd[3] = 8'h00; zv[3] = 1'b0; zr[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            z_up.Data  = zd[i];
            z_up.Valid = zv[i];
            z_dn.Ready = zr[i];
            @(negedge Clk);
            chk("pass_q", 32'(z_dn.Data), 32'(zd[i]));
            chk("pass_out_valid", 32'(z_dn.Valid), 32'(zv[i]));
            chk("pass_in_ready", 32'(z_up.Ready), 32'(zr[i]));
            chk("pass_count", 32'(z_count), 32'd0);
            @(posedge Clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cr_pipe_reg_hs.md
Name: cr_pipe_reg_hs

Overview:
Elastic pipeline register: a chain of pStages valid/ready skid stages carrying a pWidth-bit payload at full throughput with backpressure.
Successor to the plain fixed-latency pipe register for paths where the consumer can stall.
Every stage's ready is registered, so no combinational ready path spans the chain; stages can be added during timing closure without breaking flow control.
Sits between any valid/ready producer and consumer in the datapath.

Parameters:
pWidth, 10, payload width in bits (>=1)
pStages, 2, number of skid stages; 0 = combinational passthrough
pCntW, $clog2(2*pStages+1) (1 when pStages=0), width of the Count output; derived, do not override

Ports:
Clk  input  1  clock, all logic on rising edge
Rst_n  input  1  synchronous active-low reset, sampled on rising Clk
StaticResetData  input  pWidth  value loaded into every data register at reset
InValid  input  1  upstream data valid
InReady  output  1  block can accept (registered when pStages>0)
D  input  pWidth  upstream payload
OutValid  output  1  Q holds valid data
OutReady  input  1  downstream accepts
Q  output  pWidth  downstream payload
Count  output  pCntW  number of payloads currently held
Flush  input  1  present only when CR_PIPE_REG_HS_FLUSH_EN is defined

Behaviour:
- Reset (Rst_n=0 at rising Clk): all valid flags 0; all data registers, including Q, = StaticResetData; Count=0; InReady=1 on the first cycle after reset.
- Transfer rule: a transfer occurs in a cycle where Valid && Ready is high on that interface.
  - Producer must hold InValid and D stable until transferred. The block holds OutValid and Q stable until transferred.
- Per stage (sub-module cr_pipe_skid) holds two registers, main and skid:
  - in_ready = !skid_valid, registered.
  - On input transfer: if main is empty or main is leaving this cycle, the word goes to main. Otherwise it goes to skid.
  - On output transfer: if skid is valid, skid moves to main and skid is cleared. Otherwise main_valid follows the input transfer.
  - Simultaneous input and output transfer with skid empty: main is replaced; occupancy unchanged.
  - out_valid = main_valid; out_data = main.
- Chain: stage k output feeds stage k+1 input. InReady = stage 0 in_ready; OutValid/Q = last stage.
- Latency: D accepted at cycle N appears on Q with OutValid=1 at cycle N+pStages, provided OutReady stays 1.
- Throughput: 1 word/cycle sustained when OutReady=1.
- Capacity: 2*pStages words. InReady drops only when stage 0's skid is full.
- Ordering: strict FIFO; no word is dropped or duplicated under any stall pattern.
- Count: +1 on input transfer, -1 on output transfer, unchanged when both or neither occur. It never exceeds 2*pStages.
- Data registers are not cleared when a word leaves. Q keeps its stale value while OutValid=0.
- Reset mid-operation: all held words are discarded; state identical to the post-reset state.
- pStages=0: InReady=OutReady, OutValid=InValid, Q=D combinationally, Count=0. StaticResetData is unused.

Optional Feature:
CR_PIPE_REG_HS_FLUSH_EN
- Defined:
  - Flush port exists. Flush=1 at a rising edge clears every valid flag and Count to 0. Data registers keep their values.
  - Any input transfer in that cycle is discarded. Any output transfer in that cycle still completes at the consumer.
  - InReady=1 the next cycle.
  - Rst_n=0 has priority over Flush.
- Undefined: no Flush port and no flush logic.

Decomposition:
- Package cr_pipe_pkg:
  - count-width function clog2_cnt(stages), used to derive pCntW;
  - localparam CR_PIPE_SKID_DEPTH=2.
- One sub-module, cr_pipe_skid (params pWidth; ports Clk, Rst_n, StaticResetData, in/out valid/ready/data, plus flush under the macro).
  - The top level generates the chain of pStages instances.
  - The top level keeps the occupancy counter and the pStages=0 branch.

Test Plan:
- pWidth=8, pStages=3, StaticResetData=8'hA5, hold Rst_n=0 two cycles -> Q=8'hA5, OutValid=0, Count=0; InReady=1 after release.
- Stream 0x01..0x10 with InValid=1, OutReady=1 -> first word on Q 3 cycles after acceptance; one word per cycle, in order; Count steady at 3.
- OutReady=0 while streaming -> exactly 6 words accepted, then InReady=0 and Count=6. Raise OutReady -> all 6 drain in order with no gaps or duplicates; Count reaches 0.
- Random InValid/OutReady at 50% for 10k cycles against a scoreboard -> zero mismatches; Count equals scoreboard depth every cycle.
- Rst_n=0 for one cycle with Count=4 -> next cycle Count=0, OutValid=0, Q=StaticResetData; subsequent traffic is correct.
- With CR_PIPE_REG_HS_FLUSH_EN, pulse Flush at Count=5 while InValid=1 -> Count=0, OutValid=0 next cycle; the flushed-cycle input never appears on Q.
- pStages=0 variant -> Q tracks D and InReady tracks OutReady in the same cycle.
